// File: rtl/stack_demap_ctrl.sv
// Sequencer for the 48-entry demapper reversal stack: fills one block, inserts the rewind
// gaps the stack counters need, then drains the block in reverse under downstream permission.
module stack_demap_ctrl #(
    parameter int MEM = 48,
    parameter int CW  = 6,
    parameter int BW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          stk_we,
    output logic          stk_re,
    input  logic          stk_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic [BW-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FGAP  = 2'd1,
        DRAIN = 2'd2,
        RGAP  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(MEM - 1);

    state_t          state_r, state_s;
    logic [CW-1:0]   wr_cnt_r, wr_cnt_s;
    logic [CW-1:0]   rd_cnt_r, rd_cnt_s;
    logic [BW-1:0]   blk_cnt_r, blk_cnt_s;
    logic            last_r, last_s;

    // Handshake strobes toward the stack and upstream are combinational in the data cycle
    always_comb begin
        in_ready = (state_r == FILL);
        stk_we   = in_valid & (state_r == FILL);
        stk_re   = out_ready & (state_r == DRAIN);
        out_last = last_r & stk_valid;
        busy     = (state_r != FILL) | (wr_cnt_r != {CW{1'b0}}) | last_r;
        blk_cnt  = blk_cnt_r;
    end

    // Next-state and counter update; the gap states each last exactly one cycle
    always_comb begin
        state_s   = state_r;
        wr_cnt_s  = wr_cnt_r;
        rd_cnt_s  = rd_cnt_r;
        blk_cnt_s = blk_cnt_r;
        last_s    = stk_re & (rd_cnt_r == CNT_LAST);
        case (state_r)
            FILL: begin
                if (stk_we) begin
                    if (wr_cnt_r == CNT_LAST) begin
                        wr_cnt_s = {CW{1'b0}};
                        state_s  = FGAP;
                    end else begin
                        wr_cnt_s = wr_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_cnt_s = wr_cnt_r;
                end
            end
            FGAP: begin
                state_s = DRAIN;
            end
            DRAIN: begin
                if (stk_re) begin
                    if (rd_cnt_r == CNT_LAST) begin
                        rd_cnt_s  = {CW{1'b0}};
                        blk_cnt_s = blk_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                        state_s   = RGAP;
                    end else begin
                        rd_cnt_s = rd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    rd_cnt_s = rd_cnt_r;
                end
            end
            RGAP: begin
                state_s = FILL;
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // State and counter registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= FILL;
            wr_cnt_r  <= {CW{1'b0}};
            rd_cnt_r  <= {CW{1'b0}};
            blk_cnt_r <= {BW{1'b0}};
            last_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_cnt_r  <= wr_cnt_s;
            rd_cnt_r  <= rd_cnt_s;
            blk_cnt_r <= blk_cnt_s;
            last_r    <= last_s;
        end
    end

endmodule

// File: tb/tb_stack_demap_ctrl.sv
// Bench for stack_demap_ctrl: a behavioural LIFO stands in for the stack, and a block-level
// model predicts handshakes, block count and the reversed output order.
module tb_stack_demap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        stk_we;
    logic        stk_re;
    logic        stk_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [7:0]  blk_cnt;

    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] stk_q[$];

    typedef struct {
        logic [31:0] d;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] blk_words[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          m_acc, m_rd, m_blk, next_word, words_out;
    bit          m_g1, m_vld;
    int          b0, w0;

    stack_demap_ctrl #(.MEM(48), .CW(6), .BW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stk_we    (stk_we),
        .stk_re    (stk_re),
        .stk_valid (stk_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    // Reversal stack stand-in: one-cycle read latency, cleared by the shared reset
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_q.delete();
            stk_valid <= 1'b0;
            dout      <= 32'd0;
        end else begin
            if (stk_we) stk_q.push_back(din);
            if (stk_re) begin
                if (stk_q.size() > 0) dout <= stk_q.pop_back();
                else                  dout <= 32'hDEAD_BEEF;
            end
            stk_valid <= stk_re;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc = 0; m_rd = 0; m_blk = 0; m_g1 = 0; m_vld = 0;
        exp_q.delete();
        blk_words.delete();
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge
    task automatic step();
        bit   filling, fgap, drain, rgap, e_we, e_re, e_busy;
        exp_t e;
        @(negedge clk);
        filling = (m_acc < 48);
        fgap    = (m_acc == 48) && !m_g1;
        drain   = m_g1 && (m_rd < 48);
        rgap    = m_g1 && (m_rd == 48);
        e_we    = filling && in_valid;
        e_re    = drain && out_ready;
        e_busy  = !(filling && (m_acc == 0));
        chk("in_ready", {31'd0, in_ready}, {31'd0, filling});
        chk("stk_we", {31'd0, stk_we}, {31'd0, e_we});
        chk("stk_re", {31'd0, stk_re}, {31'd0, e_re});
        chk("busy", {31'd0, busy}, {31'd0, e_busy});
        chk("blk_cnt", {24'd0, blk_cnt}, m_blk);
        chk("stk_valid", {31'd0, stk_valid}, {31'd0, m_vld});
        if (stk_valid === 1'b1) begin
            chk("word_avail", {31'd0, stk_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", dout, e.d);
                chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                words_out++;
            end
        end else begin
            chk("out_last_idle", {31'd0, out_last}, 32'd0);
        end
        m_vld = e_re;
        if (e_we) begin
            blk_words.push_back(din);
            next_word++;
            m_acc++;
            if (m_acc == 48) begin
                for (int i = 47; i >= 0; i--) exp_q.push_back('{blk_words[i], (i == 0)});
            end
        end
        if (fgap) m_g1 = 1'b1;
        if (e_re) begin
            m_rd++;
            if (m_rd == 48) m_blk = (m_blk + 1) % 256;
        end
        if (rgap) begin
            m_acc = 0; m_rd = 0; m_g1 = 1'b0;
            blk_words.delete();
        end
        @(posedge clk);
        #1;
        din = next_word;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_stk_we"}, {31'd0, stk_we}, 32'd0);
        chk({tag, "_stk_re"}, {31'd0, stk_re}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_blk_cnt"}, {24'd0, blk_cnt}, 32'd0);
    endtask

    initial begin
        // Reset state
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = 32'd0;
        next_word = 0; words_out = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b1;

        // Block of 48 back-to-back words, free-running drain
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (48) step();
        in_valid = 1'b0;
        repeat (50) step();
        chk("t2_in_ready_98", {31'd0, in_ready}, 32'd1);
        chk("t2_blk_cnt", {24'd0, blk_cnt}, 32'd1);
        chk("t2_words_out", words_out, 32'd48);

        // Alternate-cycle upstream valid
        for (int i = 0; i < 96; i++) begin
            in_valid = (i % 2 == 0);
            step();
        end
        in_valid = 1'b0;
        repeat (60) step();
        chk("t3_blk_cnt", {24'd0, blk_cnt}, 32'd2);

        // Downstream stall of 5 cycles at read 20
        in_valid = 1'b1;
        repeat (48) step();
        in_valid = 1'b0;
        for (int k = 0; k < 200 && !(m_g1 && m_rd == 20); k++) step();
        chk("t4_reach_rd20", m_rd, 32'd20);
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        repeat (40) step();
        chk("t4_words_out", words_out, 32'd144);

        // Three blocks with upstream valid held high
        b0 = m_blk; w0 = words_out;
        in_valid = 1'b1;
        repeat (3 * 98) step();
        chk("t5_blk_cnt", {24'd0, blk_cnt}, (b0 + 3) % 256);
        chk("t5_words", words_out - w0, 32'd144);

        // Random upstream/downstream pacing
        for (int i = 0; i < 500; i++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset in the middle of a drain at read 10
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 400 && !(m_g1 && m_rd == 10); k++) step();
        chk("t6_reach_rd10", m_rd, 32'd10);
        in_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("t6");
        @(posedge clk);
        #1;
        reset = 1'b1;
        next_word = 100; din = 32'd100; w0 = words_out;
        in_valid = 1'b1;
        repeat (48) step();
        in_valid = 1'b0;
        repeat (60) step();
        chk("t6_blk_cnt", {24'd0, blk_cnt}, 32'd1);
        chk("t6_words", words_out - w0, 32'd48);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
